// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller:
// FSM state encoding, segment constants and the BCD digit pattern table.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segments, bit order g..a (MSB = g)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;

    // Index n holds the pattern for digit n
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // 10^n, used for the elaboration-time digit-count check
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   bcd   - 4-bit BCD digit
//   seg_c - active-low segments g..a; non-decimal codes give all segments off
module seg7_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg_c = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/seg7_bin_display_ctrl.sv
// Binary-to-seven-segment display controller. A start strobe captures din,
// an iterative shift-add-3 converts it to BCD over DIN_W cycles, and the
// resulting digits are latched and decoded onto the HEX displays.
// Ports:
//   CLOCK_50  - system clock
//   reset     - asynchronous active-high reset
//   start     - convert request, honoured only when idle
//   din       - binary value captured with an accepted start
//   blank_lz  - blank leading-zero digits (units digit always shown)
//   lamp_test - drive every segment on
//   busy      - conversion in progress (SHIFT or DONE)
//   done      - one-cycle pulse when new digits appear
//   HEX       - active-low segments, HEX[6:0] is the units digit
module seg7_bin_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIN_W = 9,
    parameter int unsigned NDIG  = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [DIN_W-1:0]  din,
    input  logic              blank_lz,
    input  logic              lamp_test,
    output logic              busy,
    output logic              done,
    output logic [7*NDIG-1:0] HEX
);

    localparam int unsigned BCD_W = 4 * NDIG;
    localparam int unsigned CNT_W = $clog2(DIN_W + 1);
    localparam int unsigned SH_W  = BCD_W + DIN_W;

    // Every DIN_W-bit value must fit in NDIG decimal digits
    if (pow10(NDIG) <= (64'd1 << DIN_W)) begin : g_width_check
        $error("seg7_bin_display_ctrl: NDIG too small for DIN_W");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DIN_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   disp_q,  disp_d;
    logic               busy_d,  done_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SH_W-1:0]    shifted;
    logic [NDIG-1:0]    blank_c;
    logic               lead_zero;

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state, shift-add-3 datapath and registered flag values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = din;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = shifted[DIN_W-1:0];
                bcd_d = shifted[SH_W-1:DIN_W];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    disp_d  = shifted[SH_W-1:DIN_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Digit i>0 blanks when it and every higher digit are zero
    always_comb begin
        blank_c   = '0;
        lead_zero = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            lead_zero  = lead_zero & (disp_q[4*i +: 4] == 4'd0);
            blank_c[i] = blank_lz & lead_zero;
        end
    end

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_digit
        logic [6:0] seg_c;

        seg7_digit_decoder u_dec (
            .bcd   (disp_q[4*g +: 4]),
            .seg_c (seg_c)
        );

        assign HEX[7*g +: 7] = lamp_test  ? SEG_ALL   :
                               blank_c[g] ? SEG_BLANK : seg_c;
    end

endmodule

// File: tb/tb_seg7_bin_display_ctrl.sv
// Scoreboard bench for seg7_bin_display_ctrl: the driver pushes the expected
// result of each accepted start, the monitor pops on every done pulse and
// checks HEX/busy/done every cycle against a decimal-arithmetic model.
module tb_seg7_bin_display_ctrl;

    localparam int DIN_W = 9;
    localparam int NDIG  = 3;

    logic              CLOCK_50;
    logic              reset;
    logic              start;
    logic [DIN_W-1:0]  din;
    logic              blank_lz;
    logic              lamp_test;
    logic              busy;
    logic              done;
    logic [7*NDIG-1:0] HEX;

    seg7_bin_display_ctrl #(.DIN_W(DIN_W), .NDIG(NDIG)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .blank_lz  (blank_lz),
        .lamp_test (lamp_test),
        .busy      (busy),
        .done      (done),
        .HEX       (HEX)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_k = -1000;
    int   disp_val = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   finish_req = 1'b0;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Displayed pattern for a decimal value; digit i>0 blanks when v < 10^i
    function automatic logic [7*NDIG-1:0] exp_hex(input int v, input bit blz, input bit lt);
        logic [7*NDIG-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (lt)
                r[7*i +: 7] = 7'b0000000;
            else if (blz && i > 0 && v < p)
                r[7*i +: 7] = 7'b1111111;
            else
                r[7*i +: 7] = pat[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (reset) begin
            q.delete();
            disp_val = 0;
        end else if (done) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                disp_val = e.val;
            end
        end else if (q.size() > 0 && cyc >= q[0].due) begin
            e = q.pop_front();
            check("done_missing", 64'(done), 64'(1));
            disp_val = e.val;
        end
        check("busy", 64'(busy), 64'((!reset && cyc >= last_k && cyc <= last_k + DIN_W) ? 1 : 0));
        if (reset) check("done_in_reset", 64'(done), 64'(0));
        check("hex", 64'(HEX), 64'(exp_hex(disp_val, blank_lz, lamp_test)));

        if (finish_req) begin
            check("pending_results", 64'(q.size()), 64'(0));
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end
    end

    // Issue a one-cycle start; the model accepts it only when the FSM is idle
    task automatic issue_start(input int v);
        int k;
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        din   = DIN_W'(v);
        k = cyc + 1;
        if (k >= last_k + DIN_W + 2) begin
            q.push_back('{val: v, due: k + DIN_W});
            last_k = k;
        end
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        din   = DIN_W'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
    endtask

    task automatic set_mode(input bit blz, input bit lt);
        @(posedge CLOCK_50); #1;
        blank_lz  = blz;
        lamp_test = lt;
    endtask

    task automatic do_reset(input int n);
        @(posedge CLOCK_50); #1;
        reset  = 1'b1;
        last_k = -1000;
        wait_cycles(n);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; din = '0; blank_lz = 1'b0; lamp_test = 1'b0;
        wait_cycles(3);
        #1 reset = 1'b0;
        wait_cycles(2);

        issue_start(511);
        wait_cycles(12);

        set_mode(1'b1, 1'b0);
        issue_start(7);
        wait_cycles(12);
        set_mode(1'b0, 1'b0);
        wait_cycles(3);

        issue_start(42);
        wait_cycles(2);
        issue_start(99);
        wait_cycles(12);

        issue_start(300);
        wait_cycles(4);
        do_reset(2);
        wait_cycles(2);
        issue_start(128);
        wait_cycles(12);

        set_mode(1'b0, 1'b1);
        issue_start(256);
        wait_cycles(12);
        set_mode(1'b0, 1'b0);
        wait_cycles(3);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0)
                set_mode(1'($urandom), ($urandom_range(0, 5) == 0));
            wait_cycles($urandom_range(0, 13));
            issue_start(int'($urandom_range(0, 511)));
        end
        set_mode(1'b0, 1'b0);
        wait_cycles(20);
        finish_req = 1'b1;
    end

endmodule
